// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package mem_resp_pkg;

  localparam int DATA_W  = 16;
  localparam int LAT_MIN = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte address to word index; the upper bits are kept so callers can range-check them.
  function automatic logic [15:0] word_index(input logic [15:0] byte_addr);
    return {1'b0, byte_addr[15:1]};
  endfunction

endpackage

// File: rtl/mem_resp_ctrl_if.sv
// Request/response bus between the Memory stage (master) and the memory responder (slave).
interface mem_resp_ctrl_if;
  import mem_resp_pkg::*;

  logic              enable;
  logic              wr;
  logic [15:0]       addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              stall;
  logic              done;
  logic              err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, stall, done, err
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, stall, done, err
  );
endinterface

// File: rtl/mem_resp_array.sv
// Word storage for the responder: synchronous write, combinational read of the same address.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // The controller registers this value itself at the access edge.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_resp_ctrl.sv
// Multi-cycle memory responder: captures one request, waits LAT cycles, then
// performs the access and pulses done with read data and error status.
module mem_resp_ctrl
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_resp_ctrl_if.slave   bus
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  if (LAT < LAT_MIN) begin : g_bad_lat
    $error("mem_resp_ctrl: LAT must be at least 1");
  end

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_out_q;
  logic              stall_q;
  logic              done_q;
  logic              err_q;

  logic [15:0]       widx;
  logic [ADDR_W-1:0] idx;
  logic              acc_err;
  logic              acc_edge;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Everything about the access is derived from the captured copy, never the live bus.
  assign widx     = word_index(addr_q);
  assign idx      = widx[ADDR_W-1:0];
  assign acc_err  = addr_q[0] | (|(widx >> ADDR_W));
  assign acc_edge = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we   = acc_edge && wr_q && !acc_err;

  mem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            addr_q  <= bus.addr;
            wr_q    <= bus.wr;
            wdata_q <= bus.data_in;
            cnt_q   <= CNT_LOAD;
            stall_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= acc_err;
            if (acc_err) begin
              data_out_q <= '0;
            end else if (!wr_q) begin
              data_out_q <= mem_rdata;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          stall_q <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.stall    = stall_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench for mem_resp_ctrl: three instances with LAT = 1, 2 and 4.
module tb_mem_resp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_v = 3'b000;
  logic [2:0]       en_v  = 3'b000;
  logic [2:0]       wr_v  = 3'b000;
  logic [2:0][15:0] addr_v = '0;
  logic [2:0][15:0] din_v  = '0;
  logic [2:0][15:0] dout_v;
  logic [2:0]       stall_v;
  logic [2:0]       done_v;
  logic [2:0]       err_v;

  int n_total = 0;
  int n_bad   = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    mem_resp_ctrl_if bus ();
    assign bus.enable  = en_v[gi];
    assign bus.wr      = wr_v[gi];
    assign bus.addr    = addr_v[gi];
    assign bus.data_in = din_v[gi];
    assign dout_v[gi]  = bus.data_out;
    assign stall_v[gi] = bus.stall;
    assign done_v[gi]  = bus.done;
    assign err_v[gi]   = bus.err;
    mem_resp_ctrl #(.ADDR_W(8), .LAT(L)) u_dut (
      .clk (clk),
      .rst (rst_v[gi]),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input int k, input string tag);
    chk({tag, ".stall"}, 16'(stall_v[k]), 16'h0);
    chk({tag, ".done"},  16'(done_v[k]),  16'h0);
    chk({tag, ".err"},   16'(err_v[k]),   16'h0);
    chk({tag, ".dout"},  dout_v[k],       16'h0000);
  endtask

  // One request starting in an IDLE cycle; checks every BUSY cycle and the DONE cycle.
  task automatic access(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic exp_err, input logic [15:0] exp_dout, input string tag,
                        input bit scramble, input bit keep_en);
    @(negedge clk);
    chk({tag, ".idle_stall"}, 16'(stall_v[k]), 16'h0);
    chk({tag, ".idle_err"},   16'(err_v[k]),   16'h0);
    en_v[k] = 1'b1; wr_v[k] = w; addr_v[k] = a; din_v[k] = d;
    for (int c = 1; c <= lat_of(k); c++) begin
      @(negedge clk);
      chk({tag, ".busy_stall"}, 16'(stall_v[k]), 16'h1);
      chk({tag, ".busy_done"},  16'(done_v[k]),  16'h0);
      if (scramble && c == 1) begin
        addr_v[k] = 16'h0032;
        din_v[k]  = 16'hDEAD;
      end
    end
    @(negedge clk);
    chk({tag, ".done"},  16'(done_v[k]),  16'h1);
    chk({tag, ".stall"}, 16'(stall_v[k]), 16'h0);
    chk({tag, ".err"},   16'(err_v[k]),   16'(exp_err));
    chk({tag, ".dout"},  dout_v[k],       exp_dout);
    if (!keep_en) en_v[k] = 1'b0;
    $display("txn %s lat=%0d wr=%0b addr=%h din=%h -> err=%0b dout=%h",
             tag, lat_of(k), w, a, d, err_v[k], dout_v[k]);
  endtask

  // Write aborted by reset in BUSY cycle n_busy, asserted between clock edges.
  task automatic abort_write(input int k, input logic [15:0] a, input logic [15:0] d,
                             input int n_busy, input string tag);
    @(negedge clk);
    en_v[k] = 1'b1; wr_v[k] = 1'b1; addr_v[k] = a; din_v[k] = d;
    repeat (n_busy) @(negedge clk);
    chk({tag, ".busy_stall"}, 16'(stall_v[k]), 16'h1);
    #2 rst_v[k] = 1'b0;
    #1 chk_reset_outs(k, tag);
    en_v[k] = 1'b0;
    @(negedge clk);
    rst_v[k] = 1'b1;
    $display("txn %s lat=%0d write addr=%h aborted in busy cycle %0d", tag, lat_of(k), a, n_busy);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    for (int k = 0; k < 3; k++) chk_reset_outs(k, "por");
    @(negedge clk); rst_v = 3'b111;
    repeat (2) @(negedge clk);
    #2 rst_v = 3'b000;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset_outs(k, "midrst");
    rst_v = 3'b111;

    // LAT = 2 instance: main function and boundaries
    access(1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, "wr10",     1'b0, 1'b0);
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, "rd10",     1'b0, 1'b0);
    access(1, 1'b1, 16'h0011, 16'h1234, 1'b1, 16'h0000, "wr11_una", 1'b0, 1'b0);
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, "rd10_b",   1'b0, 1'b0);
    access(1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h0000, "rd200_oor", 1'b0, 1'b0);
    access(1, 1'b1, 16'h0032, 16'h1111, 1'b0, 16'h0000, "wr32",     1'b0, 1'b0);
    access(1, 1'b1, 16'h0030, 16'h5A5A, 1'b0, 16'h0000, "wr30_scr", 1'b1, 1'b0);
    access(1, 1'b0, 16'h0032, 16'h0000, 1'b0, 16'h1111, "rd32",     1'b0, 1'b0);
    access(1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5A5A, "rd30",     1'b0, 1'b0);

    // Enable left high through DONE: exactly one more access
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, "rd10_hold", 1'b0, 1'b1);
    @(negedge clk);
    chk("hold.idle_stall", 16'(stall_v[1]), 16'h0);
    @(negedge clk);
    chk("hold.busy1", 16'(stall_v[1]), 16'h1);
    en_v[1] = 1'b0;
    @(negedge clk);
    chk("hold.busy2", 16'(stall_v[1]), 16'h1);
    @(negedge clk);
    chk("hold.done",  16'(done_v[1]), 16'h1);
    chk("hold.dout",  dout_v[1],      16'hBEEF);
    @(negedge clk);
    chk("hold.after_done",  16'(done_v[1]),  16'h0);
    chk("hold.after_stall", 16'(stall_v[1]), 16'h0);
    @(negedge clk);
    chk("hold.no_third", 16'(stall_v[1]), 16'h0);
    chk("hold.dout_keep", dout_v[1], 16'hBEEF);
    $display("txn hold lat=2 extra read addr=0010 dout=%h", dout_v[1]);

    access(1, 1'b1, 16'h0020, 16'hAAAA, 1'b0, 16'hBEEF, "wr20", 1'b0, 1'b0);
    abort_write(1, 16'h0020, 16'h5555, 1, "abort2");
    access(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAAAA, "rd20", 1'b0, 1'b0);

    // LAT = 1 and LAT = 4 instances, reset in their last BUSY cycle
    for (int k = 0; k < 3; k += 2) begin
      access(k, 1'b1, 16'h0020, 16'hAAAA, 1'b0, 16'h0000, "wr20_l", 1'b0, 1'b0);
      access(k, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAAAA, "rd20_l", 1'b0, 1'b0);
      abort_write(k, 16'h0020, 16'h5555, lat_of(k), "abort_l");
      access(k, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAAAA, "rd20_post", 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
